// File: rtl/alarm_match_multi.sv
// Multi-channel alarm matcher: edge-detected time matches start a ring that
// can be stopped, snoozed a bounded number of times, or left to time out.
module alarm_match_multi #(
    parameter int NUM_ALARMS   = 4,
    parameter int TIME_W       = 17,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int SNOOZE_MAX   = 3,
    localparam int ID_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int SC_W = ($clog2(SNOOZE_MAX + 1) > 0) ? $clog2(SNOOZE_MAX + 1) : 1
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic                         SEC_TICK,
    input  logic [TIME_W-1:0]            CURRENT_TIME,
    input  logic [NUM_ALARMS*TIME_W-1:0] ALARM_TIME,
    input  logic [NUM_ALARMS-1:0]        ALARM_EN,
    input  logic                         STOP,
    input  logic                         SNOOZE,
    output logic                         ALARM_DOING,
    output logic                         SNOOZING,
    output logic [ID_W-1:0]              ACTIVE_ID,
    output logic [SC_W-1:0]              SNOOZE_CNT,
    output logic                         TIMED_OUT,
    output logic [1:0]                   DBG_STATE
);

    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [NUM_ALARMS-1:0] match, match_q, hit;
    logic                  any_hit;
    logic [ID_W-1:0]       winner;
    logic                  active_en;
    logic                  ring_last, snz_last, snooze_ok;
    logic [RW-1:0]         ring_cnt, ring_cnt_nx;
    logic [SW-1:0]         snz_tmr, snz_tmr_nx;
    logic [ID_W-1:0]       active_id_nx;
    logic [SC_W-1:0]       snooze_cnt_nx;
    logic                  timed_out_nx;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = ALARM_EN[i] && (CURRENT_TIME == ALARM_TIME[i*TIME_W +: TIME_W]);
    end

    // match_q resets to all ones so an equality already present at reset release never fires
    assign hit     = match & ~match_q;
    assign any_hit = |hit;

    always_comb begin
        winner    = '0;
        active_en = 1'b0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (hit[i]) winner = ID_W'(i);
        for (int i = 0; i < NUM_ALARMS; i++)
            if (ACTIVE_ID == ID_W'(i)) active_en = ALARM_EN[i];
    end

    assign ring_last = SEC_TICK && (ring_cnt == RW'(RING_TIMEOUT - 1));
    assign snz_last  = SEC_TICK && (snz_tmr == SW'(SNOOZE_SEC - 1));
    assign snooze_ok = (SNOOZE_CNT < SC_W'(SNOOZE_MAX));

    // Branch order inside each state encodes the event priority
    always_comb begin
        state_nx      = state;
        ring_cnt_nx   = ring_cnt;
        snz_tmr_nx    = snz_tmr;
        active_id_nx  = ACTIVE_ID;
        snooze_cnt_nx = SNOOZE_CNT;
        timed_out_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_hit) begin
                    state_nx      = ST_RINGING;
                    active_id_nx  = winner;
                    snooze_cnt_nx = '0;
                    ring_cnt_nx   = '0;
                end
            end
            ST_RINGING: begin
                if (STOP || !active_en) begin
                    state_nx = ST_IDLE;
                end else if (ring_last) begin
                    state_nx     = ST_IDLE;
                    timed_out_nx = 1'b1;
                end else if (SNOOZE && snooze_ok) begin
                    state_nx      = ST_SNOOZE;
                    snooze_cnt_nx = SNOOZE_CNT + SC_W'(1);
                    snz_tmr_nx    = '0;
                end else if (SEC_TICK) begin
                    ring_cnt_nx = ring_cnt + RW'(1);
                end
            end
            ST_SNOOZE: begin
                if (STOP || !active_en) begin
                    state_nx = ST_IDLE;
                end else if (snz_last) begin
                    state_nx    = ST_RINGING;
                    ring_cnt_nx = '0;
                end else if (any_hit) begin
                    state_nx      = ST_RINGING;
                    active_id_nx  = winner;
                    snooze_cnt_nx = '0;
                    ring_cnt_nx   = '0;
                end else if (SEC_TICK) begin
                    snz_tmr_nx = snz_tmr + SW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state       <= ST_IDLE;
            match_q     <= '1;
            ring_cnt    <= '0;
            snz_tmr     <= '0;
            ACTIVE_ID   <= '0;
            SNOOZE_CNT  <= '0;
            ALARM_DOING <= 1'b0;
            SNOOZING    <= 1'b0;
            TIMED_OUT   <= 1'b0;
        end else begin
            state       <= state_nx;
            match_q     <= match;
            ring_cnt    <= ring_cnt_nx;
            snz_tmr     <= snz_tmr_nx;
            ACTIVE_ID   <= active_id_nx;
            SNOOZE_CNT  <= snooze_cnt_nx;
            ALARM_DOING <= (state_nx == ST_RINGING);
            SNOOZING    <= (state_nx == ST_SNOOZE);
            TIMED_OUT   <= timed_out_nx;
        end
    end

    assign DBG_STATE = state;

endmodule

// File: tb/tb_alarm_match_multi.sv
// Bench for alarm_match_multi: directed vector table, long timeout/snooze
// sequences, then random traffic compared against a seconds-based model.
module tb_alarm_match_multi;

    localparam int NA = 4;
    localparam int TW = 17;
    localparam int RING_TIMEOUT = 60;
    localparam int SNOOZE_SEC = 300;
    localparam int SNOOZE_MAX = 3;

    logic             clk;
    logic             resetn;
    logic             sec_tick;
    logic [TW-1:0]    current_time;
    logic [NA*TW-1:0] alarm_time;
    logic [NA-1:0]    alarm_en;
    logic             stop;
    logic             snooze;
    logic             alarm_doing;
    logic             snoozing;
    logic [1:0]       active_id;
    logic [1:0]       snooze_cnt;
    logic             timed_out;
    logic [1:0]       dbg_state;

    alarm_match_multi #(
        .NUM_ALARMS(NA), .TIME_W(TW), .RING_TIMEOUT(RING_TIMEOUT),
        .SNOOZE_SEC(SNOOZE_SEC), .SNOOZE_MAX(SNOOZE_MAX)
    ) dut (
        .CLK(clk), .RESETN(resetn), .SEC_TICK(sec_tick),
        .CURRENT_TIME(current_time), .ALARM_TIME(alarm_time), .ALARM_EN(alarm_en),
        .STOP(stop), .SNOOZE(snooze), .ALARM_DOING(alarm_doing), .SNOOZING(snoozing),
        .ACTIVE_ID(active_id), .SNOOZE_CNT(snooze_cnt), .TIMED_OUT(timed_out),
        .DBG_STATE(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing; m_secs = seconds spent in phase
    int         m_mode, m_owner, m_snoozes, m_secs;
    bit         m_to;
    logic [3:0] m_prev;

    task automatic model_step();
        logic [3:0] eq_now;
        logic [3:0] fresh;
        int first;
        m_to = 1'b0;
        if (!resetn) begin
            m_mode = 0; m_owner = 0; m_snoozes = 0; m_secs = 0; m_prev = 4'hF;
            return;
        end
        for (int i = 0; i < NA; i++)
            eq_now[i] = alarm_en[i] && (current_time == alarm_time[i*TW +: TW]);
        fresh  = eq_now & ~m_prev;
        m_prev = eq_now;
        first  = -1;
        for (int i = NA - 1; i >= 0; i--)
            if (fresh[i]) first = i;
        if (m_mode == 0) begin
            if (first >= 0) begin
                m_mode = 1; m_owner = first; m_snoozes = 0; m_secs = 0;
            end
        end else if (stop || !alarm_en[m_owner]) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (sec_tick && (m_secs + 1 == RING_TIMEOUT)) begin
                m_mode = 0; m_to = 1'b1;
            end else if (snooze && (m_snoozes < SNOOZE_MAX)) begin
                m_mode = 2; m_snoozes++; m_secs = 0;
            end else if (sec_tick) begin
                m_secs++;
            end
        end else begin
            if (sec_tick && (m_secs + 1 == SNOOZE_SEC)) begin
                m_mode = 1; m_secs = 0;
            end else if (first >= 0) begin
                m_mode = 1; m_owner = first; m_snoozes = 0; m_secs = 0;
            end else if (sec_tick) begin
                m_secs++;
            end
        end
    endtask

    function automatic logic [6:0] model_exp();
        return {m_mode == 1, m_mode == 2, 2'(m_owner), 2'(m_snoozes), m_to};
    endfunction

    // driver: inputs change on the falling edge, outputs sampled on the next falling edge
    task automatic step(input bit rstn_i, input bit tick_i, input logic [TW-1:0] t_i,
                        input logic [NA-1:0] en_i, input bit stop_i, input bit snz_i);
        resetn = rstn_i; sec_tick = tick_i; current_time = t_i;
        alarm_en = en_i; stop = stop_i; snooze = snz_i;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // scoreboard
    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        logic [6:0] want;
        exp_q.push_back(exp);
        want = exp_q.pop_front();
        got  = {alarm_doing, snoozing, active_id, snooze_cnt, timed_out};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {ring,snz,id,cnt,to}=%b required=%b at t=%0t", name, got, want, $time);
        end
    endtask

    typedef struct {
        bit         rstn;
        bit         tick;
        logic [TW-1:0] ctime;
        logic [NA-1:0] en;
        bit         stp;
        bit         snz;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit tk, input logic [TW-1:0] t, input logic [NA-1:0] e,
                       input bit sp, input bit sz, input logic [6:0] x);
        vec_t v;
        v.rstn = r; v.tick = tk; v.ctime = t; v.en = e; v.stp = sp; v.snz = sz; v.exp = x;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0] x;
        resetn = 1'b0; sec_tick = 1'b0; current_time = '0; alarm_en = '0;
        stop = 1'b0; snooze = 1'b0;
        // channels 3..0: 0x200, 0x200, 0xA1E, 0x100
        alarm_time = {17'h00200, 17'h00200, 17'h00A1E, 17'h00100};
        @(negedge clk);

        // exp = {doing, snoozing, id[1:0], cnt[1:0], timed_out}
        add(0, 0, 17'h00000, 4'b0010, 0, 0, 7'b0000000); // reset state
        add(1, 0, 17'h00000, 4'b0010, 0, 0, 7'b0000000);
        add(1, 0, 17'h00A1E, 4'b0010, 0, 0, 7'b1001000); // ch1 fires
        add(1, 0, 17'h00A1E, 4'b0010, 1, 0, 7'b0001000); // stop
        for (int i = 0; i < 5; i++)
            add(1, i[0], 17'h00A1E, 4'b0010, 0, 0, 7'b0001000); // held equality: no re-fire
        add(1, 0, 17'h00000, 4'b0010, 0, 1, 7'b0001000); // snooze in idle ignored
        add(1, 0, 17'h00200, 4'b1100, 0, 0, 7'b1010000); // ch2+ch3 -> ch2
        add(1, 0, 17'h00200, 4'b1100, 1, 0, 7'b0010000);
        add(1, 0, 17'h00000, 4'b1100, 0, 0, 7'b0010000);
        add(1, 0, 17'h00000, 4'b1100, 0, 0, 7'b0010000); // ch3 not queued
        add(1, 0, 17'h00200, 4'b1100, 0, 0, 7'b1010000);
        add(1, 1, 17'h00200, 4'b1100, 0, 1, 7'b0110010); // snooze with tick
        add(1, 1, 17'h00200, 4'b1100, 0, 0, 7'b0110010);
        add(1, 0, 17'h00200, 4'b1000, 0, 0, 7'b0010010); // owner disabled in snooze
        add(1, 0, 17'h00000, 4'b1100, 0, 0, 7'b0010010);
        add(1, 0, 17'h00200, 4'b1100, 0, 0, 7'b1010000);
        add(0, 0, 17'h00200, 4'b1100, 0, 0, 7'b0000000); // reset mid-ring
        add(1, 0, 17'h00200, 4'b1100, 0, 0, 7'b0000000); // still matching: no fire
        add(1, 0, 17'h00200, 4'b1100, 0, 0, 7'b0000000);
        add(1, 0, 17'h00100, 4'b0001, 0, 0, 7'b1000000);
        add(1, 0, 17'h00100, 4'b0001, 1, 0, 7'b0000000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].tick, vecs[i].ctime, vecs[i].en, vecs[i].stp, vecs[i].snz);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ring timeout: tick every other cycle
        step(1, 0, 17'h00000, 4'b0010, 0, 0);
        step(1, 0, 17'h00A1E, 4'b0010, 0, 0);
        check("to_start", 7'b1001000);
        for (int k = 1; k <= RING_TIMEOUT; k++) begin
            step(1, 1, 17'h00A1E, 4'b0010, 0, 0);
            check($sformatf("to_tick%0d", k), (k < RING_TIMEOUT) ? 7'b1001000 : 7'b0001001);
            step(1, 0, 17'h00A1E, 4'b0010, 0, 0);
            check($sformatf("to_gap%0d", k), (k < RING_TIMEOUT) ? 7'b1001000 : 7'b0001000);
        end

        // three full snoozes, a refused fourth, then stop+snooze together
        step(1, 0, 17'h00000, 4'b0010, 0, 0);
        step(1, 0, 17'h00A1E, 4'b0010, 0, 0);
        check("snz_start", 7'b1001000);
        for (int s = 1; s <= SNOOZE_MAX; s++) begin
            step(1, 0, 17'h00A1E, 4'b0010, 0, 1);
            x = {1'b0, 1'b1, 2'b01, 2'(s), 1'b0};
            check($sformatf("snz%0d_enter", s), x);
            for (int j = 1; j <= SNOOZE_SEC; j++) begin
                step(1, 1, 17'h00A1E, 4'b0010, 0, 0);
                x = (j < SNOOZE_SEC) ? {1'b0, 1'b1, 2'b01, 2'(s), 1'b0}
                                     : {1'b1, 1'b0, 2'b01, 2'(s), 1'b0};
                if (j >= SNOOZE_SEC - 1) check($sformatf("snz%0d_tick%0d", s, j), x);
            end
        end
        step(1, 0, 17'h00A1E, 4'b0010, 0, 1);
        check("snz_refused", 7'b1001110);
        step(1, 0, 17'h00A1E, 4'b0010, 1, 1);
        check("stop_and_snz", 7'b0001110);

        // random traffic against the model
        alarm_time = {17'h00030, 17'h00020, 17'h00020, 17'h00010};
        begin
            logic [TW-1:0] t;
            logic [NA-1:0] e;
            t = '0; e = 4'b1111;
            for (int n = 0; n < 8000; n++) begin
                if ($urandom_range(0, 7) == 0) t = 17'(16 * $urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) e = 4'($urandom_range(0, 15));
                step($urandom_range(0, 799) != 0, $urandom_range(0, 1) == 1, t, e,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0);
                check("random", model_exp());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
